// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: hazard, interrupt, syscall/eret and divider-stall controller for a 5-stage MIPS pipeline
module pipeline_ctrl_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                INTR_LINES = 6,
    parameter int                DIV_LAT    = 8,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h80000180
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_stall,
    input  logic                  id_jump,
    input  logic                  id_jr,
    input  logic [4:0]            ifid_rs_addr,
    input  logic [4:0]            ifid_rt_addr,
    input  logic [4:0]            idex_rd_addr,
    input  logic                  idex_mem_read,
    input  logic                  ex_div_start,
    input  logic [ADDR_W-1:0]     idex_pc,
    input  logic [ADDR_W-1:0]     exmem_target_pc,
    input  logic [ADDR_W-1:0]     exmem_pc,
    input  logic                  exmem_syscall,
    input  logic                  exmem_eret,
    input  logic [INTR_LINES-1:0] intr_in,
    input  logic [INTR_LINES-1:0] intr_mask,
    input  logic                  cp0_ie,
    output logic [3:0]            pc_src,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_stall,
    output logic                  exmem_stall,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  cp0_w_en,
    output logic [4:0]            exec_code,
    output logic [ADDR_W-1:0]     epc,
    output logic [ADDR_W-1:0]     vector,
    output logic                  bpu_write_en,
    output logic                  div_busy,
    output logic                  in_handler
);
    localparam int CW = $clog2(DIV_LAT);

    logic [INTR_LINES-1:0] intr_pend, intr_pend_nx;
    logic [CW-1:0]         div_cnt, div_cnt_nx;
    logic                  in_handler_nx;
    logic                  branch_hazard, load_use, take_int;

    assign branch_hazard = idex_pc != exmem_target_pc;
    assign load_use      = idex_mem_read && idex_rd_addr != 5'd0 &&
                           (idex_rd_addr == ifid_rs_addr || idex_rd_addr == ifid_rt_addr);
    assign take_int      = |intr_pend && cp0_ie && !in_handler && !mem_stall;
    assign vector        = EXC_VECTOR;

    // state register: pending interrupts, local EXL and divider countdown
    always_ff @(posedge clk) begin
        if (!resetn) begin
            intr_pend  <= '0;
            in_handler <= 1'b0;
            div_cnt    <= '0;
        end else begin
            intr_pend  <= intr_pend_nx;
            in_handler <= in_handler_nx;
            div_cnt    <= div_cnt_nx;
        end
    end

    // priority decode of the current cycle's pipeline action
    always_comb begin
        pc_src        = 4'd5;
        {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'b0;
        {ifid_flush, idex_flush, exmem_flush}           = 3'b0;
        cp0_w_en      = 1'b0;
        exec_code     = 5'd0;
        epc           = '0;
        bpu_write_en  = 1'b0;
        div_busy      = 1'b0;
        intr_pend_nx  = intr_pend | (intr_in & intr_mask);
        in_handler_nx = in_handler;
        div_cnt_nx    = div_cnt;
        if (mem_stall) begin
            {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'hF;
        end else if (take_int) begin
            pc_src        = 4'd2;
            cp0_w_en      = 1'b1;
            epc           = branch_hazard ? exmem_target_pc : idex_pc;
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            intr_pend_nx  = '0;
            in_handler_nx = 1'b1;
            div_cnt_nx    = '0;
        end else if (exmem_syscall) begin
            pc_src        = 4'd2;
            cp0_w_en      = 1'b1;
            exec_code     = 5'd8;
            epc           = exmem_pc;
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            in_handler_nx = 1'b1;
            div_cnt_nx    = '0;
        end else if (exmem_eret && !branch_hazard) begin
            pc_src        = 4'd3;
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            in_handler_nx = 1'b0;
        end else if (branch_hazard) begin
            pc_src        = 4'd4;
            bpu_write_en  = 1'b1;
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            div_cnt_nx    = '0;
        end else if (div_cnt != '0 || ex_div_start) begin
            div_busy      = 1'b1;
            {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'hF;
            div_cnt_nx    = div_cnt != '0 ? div_cnt - 1'b1 : CW'(DIV_LAT - 1);
        end else if (load_use) begin
            pc_stall      = 1'b1;
            ifid_stall    = 1'b1;
            idex_flush    = 1'b1;
        end else if (id_jr || id_jump) begin
            pc_src        = id_jr ? 4'd1 : 4'd0;
            ifid_flush    = 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// tb_pipeline_ctrl_unit: directed and randomized checks of pipeline_ctrl_unit against a cycle-level reference model
module tb_pipeline_ctrl_unit;
    localparam int DIV_LAT = 8;
    localparam logic [31:0] VEC = 32'h80000180;

    logic clk = 0, resetn = 0;
    logic mem_stall = 0, id_jump = 0, id_jr = 0, idex_mem_read = 0, ex_div_start = 0;
    logic [4:0] ifid_rs_addr = 0, ifid_rt_addr = 0, idex_rd_addr = 0;
    logic [31:0] idex_pc = 32'h400, exmem_target_pc = 32'h400, exmem_pc = 32'h3fc;
    logic exmem_syscall = 0, exmem_eret = 0, cp0_ie = 0;
    logic [5:0] intr_in = 0, intr_mask = 0;
    logic [3:0] pc_src;
    logic pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, exmem_flush;
    logic cp0_w_en, bpu_write_en, div_busy, in_handler;
    logic [4:0] exec_code;
    logic [31:0] epc, vector;

    pipeline_ctrl_unit dut (
        .clk(clk), .resetn(resetn), .mem_stall(mem_stall), .id_jump(id_jump), .id_jr(id_jr),
        .ifid_rs_addr(ifid_rs_addr), .ifid_rt_addr(ifid_rt_addr), .idex_rd_addr(idex_rd_addr),
        .idex_mem_read(idex_mem_read), .ex_div_start(ex_div_start), .idex_pc(idex_pc),
        .exmem_target_pc(exmem_target_pc), .exmem_pc(exmem_pc), .exmem_syscall(exmem_syscall),
        .exmem_eret(exmem_eret), .intr_in(intr_in), .intr_mask(intr_mask), .cp0_ie(cp0_ie),
        .pc_src(pc_src), .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .cp0_w_en(cp0_w_en), .exec_code(exec_code), .epc(epc),
        .vector(vector), .bpu_write_en(bpu_write_en), .div_busy(div_busy), .in_handler(in_handler)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0, failed = 0;
    int cyc = 0;
    bit [5:0] m_pend, n_pend;
    bit m_inh, n_inh;
    int m_div_end, n_div_end;
    logic [51:0] exp_b;

    // reference model: divider modelled as a deadline in cycles that slides while preempted
    task automatic model();
        bit bh, lu, dp;
        logic [3:0] ps, st;
        logic [2:0] fl;
        logic w, bpu, busy;
        logic [4:0] ec;
        logic [31:0] ep;
        bh = idex_pc != exmem_target_pc;
        lu = idex_mem_read && idex_rd_addr != 0 &&
             (idex_rd_addr == ifid_rs_addr || idex_rd_addr == ifid_rt_addr);
        dp = m_div_end > cyc;
        ps = 5; st = 0; fl = 0; w = 0; ec = 0; ep = 0; bpu = 0; busy = 0;
        n_pend = m_pend | (intr_in & intr_mask);
        n_inh = m_inh;
        n_div_end = m_div_end;
        if (mem_stall) begin
            st = 4'hF;
            if (dp) n_div_end++;
        end else if (m_pend != 0 && cp0_ie && !m_inh) begin
            ps = 2; w = 1; fl = 7; ep = bh ? exmem_target_pc : idex_pc;
            n_inh = 1; n_div_end = 0; n_pend = 0;
        end else if (exmem_syscall) begin
            ps = 2; w = 1; fl = 7; ec = 8; ep = exmem_pc; n_inh = 1; n_div_end = 0;
        end else if (exmem_eret && !bh) begin
            ps = 3; fl = 7; n_inh = 0;
            if (dp) n_div_end++;
        end else if (bh) begin
            ps = 4; fl = 7; bpu = 1; n_div_end = 0;
        end else if (dp) begin
            busy = 1; st = 4'hF;
        end else if (ex_div_start) begin
            busy = 1; st = 4'hF; n_div_end = cyc + DIV_LAT;
        end else if (lu) begin
            st = 4'b1100; fl = 3'b010;
        end else if (id_jr || id_jump) begin
            ps = id_jr ? 4'd1 : 4'd0; fl = 3'b100;
        end
        exp_b = {ps, st, fl, w, ec, ep, bpu, busy, logic'(m_inh)};
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic settle(input string tag);
        #1;
        model();
        chk(tag, {12'b0, pc_src, pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
                  idex_flush, exmem_flush, cp0_w_en, exec_code, epc, bpu_write_en, div_busy,
                  in_handler}, {12'b0, exp_b});
        chk({tag, "_vector"}, {32'b0, vector}, {32'b0, VEC});
    endtask

    task automatic tick();
        model();
        @(posedge clk);
        if (!resetn) begin
            m_pend = 0; m_inh = 0; m_div_end = 0;
        end else begin
            m_pend = n_pend; m_inh = n_inh; m_div_end = n_div_end;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        mem_stall = 0; id_jump = 0; id_jr = 0; idex_mem_read = 0; ex_div_start = 0;
        ifid_rs_addr = 0; ifid_rt_addr = 0; idex_rd_addr = 0;
        idex_pc = 32'h400; exmem_target_pc = 32'h400; exmem_pc = 32'h3fc;
        exmem_syscall = 0; exmem_eret = 0; intr_in = 0;
    endtask

    initial begin
        // reset with every interrupt line asserted
        resetn = 0; intr_in = 6'h3F; intr_mask = 6'h3F; cp0_ie = 1;
        tick(); tick();
        resetn = 1; intr_in = 0;
        settle("reset");
        chk("reset_pc_src", pc_src, 5);
        chk("reset_in_handler", in_handler, 0);
        chk("reset_div_busy", div_busy, 0);
        tick();
        settle("reset_no_pend");
        chk("reset_no_pend_pc_src", pc_src, 5);
        tick();

        // load-use hazard, jump in ID suppressed
        idex_mem_read = 1; idex_rd_addr = 5; ifid_rs_addr = 5; id_jump = 1;
        settle("lu");
        chk("lu_stalls", {pc_stall, ifid_stall, idex_flush}, 3'b111);
        chk("lu_pc_src", pc_src, 5);
        tick();
        idex_rd_addr = 0; ifid_rs_addr = 0;
        settle("lu_r0");
        chk("lu_r0_stall", pc_stall, 0);
        chk("lu_r0_jump", pc_src, 0);
        tick();
        id_jump = 1; id_jr = 1; idex_mem_read = 0;
        settle("jr_wins");
        chk("jr_wins_pc_src", pc_src, 1);
        tick();
        idle();

        // full divide: busy for exactly DIV_LAT cycles
        ex_div_start = 1;
        for (int i = 0; i < DIV_LAT; i++) begin
            settle("div");
            chk($sformatf("div_busy_%0d", i), div_busy, 1);
            tick();
            ex_div_start = 0;
        end
        settle("div_done");
        chk("div_released", div_busy, 0);
        tick();

        // divide aborted by interrupt
        ex_div_start = 1; intr_mask = 6'h04; cp0_ie = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) intr_in = 6'h04;
            settle("div_abort_pre");
            chk("div_abort_busy", div_busy, 1);
            tick();
            ex_div_start = 0;
        end
        intr_in = 0;
        settle("div_abort");
        chk("div_abort_pc_src", pc_src, 2);
        chk("div_abort_code", exec_code, 0);
        chk("div_abort_busy_drop", div_busy, 0);
        tick();
        settle("div_abort_after");
        chk("div_abort_idle", div_busy, 0);
        chk("div_abort_inh", in_handler, 1);
        exmem_eret = 1;
        tick();
        idle();

        // interrupt on top of a mispredict
        idex_pc = 32'h80001000; exmem_target_pc = 32'h80002000; intr_in = 6'h01; intr_mask = 6'h01;
        settle("mis_pre");
        chk("mis_pre_pc_src", pc_src, 4);
        tick();
        settle("mis_int");
        chk("mis_int_epc", epc, 32'h80002000);
        chk("mis_int_wen", cp0_w_en, 1);
        chk("mis_int_flush", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        tick();
        idle();
        settle("mis_inh");
        chk("mis_inh_set", in_handler, 1);
        tick();

        // nested interrupt held off until the cycle after eret
        intr_in = 6'h02; intr_mask = 6'h03;
        settle("nest_hold0");
        tick();
        settle("nest_hold1");
        chk("nest_no_take", pc_src, 5);
        exmem_eret = 1;
        #1;
        settle("nest_eret");
        chk("nest_eret_pc_src", pc_src, 3);
        tick();
        exmem_eret = 0;
        settle("nest_take");
        chk("nest_take_pc_src", pc_src, 2);
        chk("nest_take_code", exec_code, 0);
        tick();
        intr_in = 0; exmem_eret = 1;
        settle("nest_exit");
        tick();
        idle();

        // syscall behind a memory stall, then a syscall inside the handler
        mem_stall = 1; exmem_syscall = 1; exmem_pc = 32'h1234;
        settle("sys_stall");
        chk("sys_stall_stalls", {pc_stall, ifid_stall, idex_stall, exmem_stall}, 4'hF);
        chk("sys_stall_wen", cp0_w_en, 0);
        tick();
        mem_stall = 0;
        settle("sys");
        chk("sys_pc_src", pc_src, 2);
        chk("sys_code", exec_code, 8);
        chk("sys_epc", epc, 32'h1234);
        tick();
        settle("sys_nested");
        chk("sys_nested_pc_src", pc_src, 2);
        tick();
        exmem_syscall = 0;
        settle("sys_nested_inh");
        chk("sys_nested_inh_kept", in_handler, 1);
        tick();

        // reset in the middle of a divide and a handler
        idle();
        ex_div_start = 1;
        settle("rst_div0");
        tick();
        ex_div_start = 0;
        settle("rst_div1");
        tick();
        resetn = 0;
        tick();
        resetn = 1;
        settle("rst_mid");
        chk("rst_mid_busy", div_busy, 0);
        chk("rst_mid_inh", in_handler, 0);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            resetn = $urandom_range(0, 199) != 0;
            mem_stall = $urandom_range(0, 7) == 0;
            id_jump = $urandom_range(0, 3) == 0;
            id_jr = $urandom_range(0, 5) == 0;
            ifid_rs_addr = 5'($urandom_range(0, 3));
            ifid_rt_addr = 5'($urandom_range(0, 3));
            idex_rd_addr = 5'($urandom_range(0, 3));
            idex_mem_read = $urandom_range(0, 2) == 0;
            ex_div_start = $urandom_range(0, 9) == 0;
            idex_pc = 32'h400 + 32'($urandom_range(0, 3)) * 4;
            exmem_target_pc = $urandom_range(0, 7) == 0 ? idex_pc + 4 : idex_pc;
            exmem_pc = $urandom;
            exmem_syscall = $urandom_range(0, 15) == 0;
            exmem_eret = $urandom_range(0, 5) == 0;
            intr_in = $urandom_range(0, 5) == 0 ? 6'($urandom) : 6'h0;
            intr_mask = 6'($urandom);
            cp0_ie = $urandom_range(0, 3) != 0;
            settle("rand");
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
